// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: countdown game timer paced by an external 1 Hz clock.
// Each rising edge of incrementClk becomes a one-cycle tick after a 2-flop
// synchronizer and an edge detector. The FSM (IDLE/RUN/EXPIRED) counts down
// from GAME_TIME. It keeps a binary count and a BCD pair that always agree.
module game_timer_ctrl #(
  parameter int GAME_TIME = 30  // countdown length in seconds, 1..59
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       incrementClk,
  input  logic       start,
  input  logic       abort,
  output logic [5:0] time_left,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       timer_expired,
  output logic       expire_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_EXPIRED
  } state_t;

  localparam logic [5:0] LP_LOAD = 6'(GAME_TIME);
  localparam logic [3:0] LP_TENS = 4'(GAME_TIME / 10);
  localparam logic [3:0] LP_ONES = 4'(GAME_TIME % 10);

  state_t r_state;
  logic   r_sync1;
  logic   r_sync2;
  logic   r_sync_d;
  logic   w_tick;

  // Synchronize the 1 Hz clock into clkIn and keep the previous value for edge detection.
  // NOTE: flops use non-blocking assignments so every register samples pre-edge values;
  // blocking here would collapse the synchronizer chain into a single stage.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= incrementClk;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // The tick is high for one cycle after the synchronized level goes 0 -> 1.
  // The counters act on it at the third clkIn edge after incrementClk rises.
  assign w_tick = r_sync2 & ~r_sync_d;

  // Control FSM. Outputs are registered alongside the state.
  // abort has priority over start, and start has priority over tick.
  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      time_left     <= LP_LOAD;
      tens          <= LP_TENS;
      ones          <= LP_ONES;
      running       <= 1'b0;
      timer_expired <= 1'b0;
      expire_pulse  <= 1'b0;
    end else begin
      expire_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (abort) begin
            time_left <= LP_LOAD;
            tens      <= LP_TENS;
            ones      <= LP_ONES;
          end else if (start) begin
            r_state   <= ST_RUN;
            running   <= 1'b1;
            time_left <= LP_LOAD;
            tens      <= LP_TENS;
            ones      <= LP_ONES;
          end
        end

        ST_RUN: begin
          if (abort) begin
            r_state   <= ST_IDLE;
            running   <= 1'b0;
            time_left <= LP_LOAD;
            tens      <= LP_TENS;
            ones      <= LP_ONES;
          end else if (start) begin
            time_left <= LP_LOAD;
            tens      <= LP_TENS;
            ones      <= LP_ONES;
          end else if (w_tick && time_left == 6'd1) begin
            r_state       <= ST_EXPIRED;
            running       <= 1'b0;
            timer_expired <= 1'b1;
            expire_pulse  <= 1'b1;
            time_left     <= 6'd0;
            tens          <= 4'd0;
            ones          <= 4'd0;
          end else if (w_tick && time_left != 6'd0) begin
            time_left <= time_left - 6'd1;
            if (ones == 4'd0) begin
              ones <= 4'd9;
              tens <= tens - 4'd1;
            end else begin
              ones <= ones - 4'd1;
            end
          end
        end

        ST_EXPIRED: begin
          if (abort) begin
            r_state       <= ST_IDLE;
            timer_expired <= 1'b0;
            time_left     <= LP_LOAD;
            tens          <= LP_TENS;
            ones          <= LP_ONES;
          end else if (start) begin
            r_state       <= ST_RUN;
            running       <= 1'b1;
            timer_expired <= 1'b0;
            time_left     <= LP_LOAD;
            tens          <= LP_TENS;
            ones          <= LP_ONES;
          end
        end

        default: begin
          r_state       <= ST_IDLE;
          running       <= 1'b0;
          timer_expired <= 1'b0;
          time_left     <= LP_LOAD;
          tens          <= LP_TENS;
          ones          <= LP_ONES;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl.
// dut_a runs with GAME_TIME=3 and dut_b with GAME_TIME=30.
// Both share the clock, reset and incrementClk; each has its own start and abort.
module tb_game_timer_ctrl;

  logic       clk;
  logic       rst;
  logic       incr;
  logic       start_a, abort_a, start_b, abort_b;
  logic [5:0] tl_a, tl_b;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;
  logic       run_a, exp_a, pulse_a, run_b, exp_b, pulse_b;

  int tests = 0;
  int fails = 0;

  game_timer_ctrl #(.GAME_TIME(3)) dut_a (
    .clkIn(clk), .reset(rst), .incrementClk(incr), .start(start_a), .abort(abort_a),
    .time_left(tl_a), .tens(tens_a), .ones(ones_a), .running(run_a),
    .timer_expired(exp_a), .expire_pulse(pulse_a)
  );

  game_timer_ctrl #(.GAME_TIME(30)) dut_b (
    .clkIn(clk), .reset(rst), .incrementClk(incr), .start(start_b), .abort(abort_b),
    .time_left(tl_b), .tens(tens_b), .ones(ones_b), .running(run_b),
    .timer_expired(exp_b), .expire_pulse(pulse_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise incrementClk and stop right after the edge at which the counters react.
  task automatic tick_rise();
    @(negedge clk) incr = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Lower incrementClk and let the synchronizer and edge detector drain.
  task automatic tick_fall();
    incr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick();
    tick_rise();
    tick_fall();
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic pulse_abort_a();
    @(negedge clk) abort_a = 1'b1;
    @(negedge clk) abort_a = 1'b0;
  endtask

  initial begin
    int exp_t;
    rst = 1'b1; incr = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_tl_a", tl_a, 3);
    check("rst_tens_a", tens_a, 0);
    check("rst_ones_a", ones_a, 3);
    check("rst_run_a", run_a, 0);
    check("rst_exp_a", exp_a, 0);
    check("rst_pulse_a", pulse_a, 0);
    check("rst_tl_b", tl_b, 30);
    check("rst_tens_b", tens_b, 3);
    check("rst_ones_b", ones_b, 0);

    // incrementClk already high at reset release: no decrement in IDLE
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rel_hi_tl", tl_a, 3);
    check("rel_hi_run", run_a, 0);
    tick_fall();

    // Basic countdown 3,2,1,0 with tick latency check
    pulse_start_a();
    check("start_run", run_a, 1);
    check("start_tl", tl_a, 3);
    @(negedge clk) incr = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_before", tl_a, 3);
    @(negedge clk);
    check("lat_third", tl_a, 2);
    check("t2_ones", ones_a, 2);
    tick_fall();
    tick();
    check("t1_tl", tl_a, 1);
    tick_rise();
    check("t0_tl", tl_a, 0);
    check("t0_exp", exp_a, 1);
    check("t0_pulse", pulse_a, 1);
    check("t0_run", run_a, 0);
    @(negedge clk);
    check("pulse_one_cycle", pulse_a, 0);
    check("exp_level", exp_a, 1);
    tick_fall();
    tick();
    check("exp_no_wrap", tl_a, 0);
    check("exp_hold", exp_a, 1);

    // EXPIRED then start -> reload; abort -> IDLE; IDLE ignores ticks
    pulse_start_a();
    check("rest_run", run_a, 1);
    check("rest_tl", tl_a, 3);
    check("rest_exp", exp_a, 0);
    pulse_abort_a();
    tick();
    tick();
    check("idle_tl", tl_a, 3);
    check("idle_run", run_a, 0);

    // abort and start in the same cycle at time_left=2
    pulse_start_a();
    tick();
    check("ab_pre_tl", tl_a, 2);
    @(negedge clk) begin abort_a = 1'b1; start_a = 1'b1; end
    @(negedge clk) begin abort_a = 1'b0; start_a = 1'b0; end
    check("ab_tl", tl_a, 3);
    check("ab_run", run_a, 0);
    check("ab_exp", exp_a, 0);
    check("ab_ones", ones_a, 3);

    // start coincident with tick: load only
    pulse_start_a();
    tick();
    check("co_pre_tl", tl_a, 2);
    @(negedge clk) incr = 1'b1;
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    check("co_tl", tl_a, 3);
    check("co_run", run_a, 1);
    tick_fall();
    tick();
    check("co_next", tl_a, 2);

    // asynchronous reset at time_left=1, between clock edges
    tick();
    check("ar_pre_tl", tl_a, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("ar_tl", tl_a, 3);
    check("ar_run", run_a, 0);
    check("ar_ones", ones_a, 3);
    @(negedge clk) rst = 1'b0;
    tick();
    tick();
    check("ar_after_tl", tl_a, 3);
    check("ar_after_exp", exp_a, 0);
    check("ar_after_pulse", pulse_a, 0);

    // GAME_TIME=30 countdown with BCD at every step
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    check("b_start_tl", tl_b, 30);
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_t = 30 - k;
      check("b_tl", tl_b, exp_t);
      check("b_tens", tens_b, exp_t / 10);
      check("b_ones", ones_b, exp_t % 10);
    end
    check("b_exp", exp_b, 1);
    check("b_run", run_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 Parameter GAME_TIME, default 30, countdown length in seconds; legal range 1..59.
REQ-002 clkIn  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 incrementClk  input  1  1 Hz square wave, asynchronous to clkIn.
REQ-005 start  input  1  synchronous request to load GAME_TIME and begin the countdown.
REQ-006 abort  input  1  synchronous request to return to IDLE.
REQ-007 time_left  output  6  seconds remaining, binary.
REQ-008 tens  output  4  BCD tens digit of time_left.
REQ-009 ones  output  4  BCD ones digit of time_left.
REQ-010 running  output  1  high while in RUN.
REQ-011 timer_expired  output  1  level, high while in EXPIRED.
REQ-012 expire_pulse  output  1  one-clkIn-cycle pulse on entry to EXPIRED.

Function
REQ-013 incrementClk SHALL pass through a 2-flop synchronizer, then a rising-edge detector producing a one-cycle internal tick.
REQ-014 Tick latency: time_left SHALL update on the 3rd clkIn rising edge after incrementClk rises (setup met).
REQ-015 FSM states: IDLE, RUN, EXPIRED; all outputs registered.
REQ-016 IDLE: start -> RUN, time_left loaded with GAME_TIME; ticks ignored.
REQ-017 RUN: each tick decrements time_left by 1; on a tick with time_left==1, time_left -> 0 and state -> EXPIRED in the same cycle.
REQ-018 expire_pulse SHALL be high exactly in the first cycle of EXPIRED (same edge that sets timer_expired).
REQ-019 EXPIRED: time_left holds 0; start -> RUN with reload; abort -> IDLE.
REQ-020 abort in RUN or EXPIRED -> IDLE with time_left reloaded to GAME_TIME; abort has priority over start and tick.
REQ-021 start while in RUN SHALL reload time_left to GAME_TIME and stay in RUN (restart).
REQ-022 Start and tick in the same cycle: load only, no decrement that cycle.
REQ-023 tens/ones SHALL be maintained as registered BCD counters updated in the same cycle as time_left: ones 0 with borrow -> 9 and tens-1; never show an invalid BCD digit.
REQ-024 tens*10+ones SHALL equal time_left in every cycle.
REQ-025 time_left SHALL never wrap below 0; no decrement outside RUN.
REQ-026 running = (state==RUN); timer_expired = (state==EXPIRED).

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, time_left=GAME_TIME, tens/ones=BCD(GAME_TIME), running=0, timer_expired=0, expire_pulse=0, synchronizer and edge-detect flops=0.
REQ-028 Reset mid-RUN SHALL abandon the countdown; no expire_pulse is produced.
REQ-029 After reset release, incrementClk already high SHALL NOT cause a decrement (state is IDLE).

Verification (GAME_TIME=3 unless noted)
REQ-030 start pulse, then 3 incrementClk rising edges -> time_left 3,2,1,0; on the 3rd, timer_expired=1, expire_pulse high one cycle, running=0.
REQ-031 GAME_TIME=30: 11 ticks after start -> time_left=19, tens=1, ones=9; tick count to 0 matches BCD at every step.
REQ-032 In RUN at time_left=2, assert abort and start same cycle -> IDLE, time_left=3, running=0.
REQ-033 start coincident with internal tick -> time_left=3 (no decrement); next tick -> 2.
REQ-034 Assert reset asynchronously at time_left=1 between clkIn edges -> outputs at reset values before next clkIn edge; following ticks no effect until start.
REQ-035 EXPIRED, then start -> RUN, time_left=3, timer_expired=0; ticks with no start in IDLE leave time_left=3.
